// File: rtl/stream_capture_engine_pkg.sv
// Shared definitions for the stream capture engine: FSM states, trigger modes,
// dump framing constants and small helpers.
package stream_capture_engine_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DUMP      = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        TRIG_IMM     = 2'd0,
        TRIG_RISE    = 2'd1,
        TRIG_FALL    = 2'd2,
        TRIG_IMM_ALT = 2'd3
    } trig_mode_t;

    localparam logic [7:0]  SYNC_BYTE0 = 8'hA5;
    localparam logic [7:0]  SYNC_BYTE1 = 8'h5A;
    localparam int unsigned HDR_LEN    = 4;

    // Bytes needed to carry one sample of w bits
    function automatic int unsigned bytes_per_sample(input int unsigned w);
        return (w + 7) / 8;
    endfunction

    // Frame header: two sync bytes followed by the 16-bit length, MSB first
    function automatic logic [7:0] header_byte(input logic [1:0] idx, input logic [15:0] len);
        logic [7:0] b;
        case (idx)
            2'd0:    b = SYNC_BYTE0;
            2'd1:    b = SYNC_BYTE1;
            2'd2:    b = len[15:8];
            default: b = len[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/stream_capture_engine_ram.sv
// Capture buffer: simple dual-port RAM, synchronous write, registered read.
// The read register holds its value when re is low.
module capture_ram #(
    parameter  int unsigned WIDTH = 16,
    parameter  int unsigned DEPTH = 2048,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/stream_capture_engine.sv
// Capture-and-dump engine: selects one sample stream, waits for a threshold
// trigger, stores a decimated frame and dumps it as a framed byte stream.
module stream_capture_engine
    import stream_capture_engine_pkg::*;
#(
    parameter  int unsigned NUM_CH  = 4,
    parameter  int unsigned WIDTH   = 16,
    parameter  int unsigned DEPTH   = 2048,
    parameter  int unsigned DECIM_W = 8,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned LW      = AW + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH*WIDTH-1:0] i_tdata,
    input  logic [NUM_CH-1:0]       i_tvalid,
    input  logic [CH_W-1:0]         ch_sel,
    input  logic [1:0]              trig_mode,
    input  logic [WIDTH-1:0]        trig_level,
    input  logic [LW-1:0]           frame_len,
    input  logic [DECIM_W-1:0]      decim,
    input  logic                    arm,
    input  logic                    abort,
    output logic [7:0]              o_tdata,
    output logic                    o_tvalid,
    input  logic                    o_tready,
    output logic [1:0]              state,
    output logic                    done
);

    localparam int unsigned BYTES = bytes_per_sample(WIDTH);
    localparam int unsigned SW    = BYTES * 8;

    state_t           state_q, state_d;
    logic [CH_W-1:0]  ch_q;
    trig_mode_t       mode_q;
    logic [WIDTH-1:0] level_q, prev_q;
    logic             prev_vld_q;
    logic [LW-1:0]    len_q, wcnt_q, samp_cnt_q;
    logic [DECIM_W-1:0] decim_q, dcnt_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [SW-1:0]    sh_q;
    logic [1:0]       hdr_cnt_q;
    logic             in_hdr_q;
    logic [2:0]       byte_cnt_q;
    logic             abort_pend_q;
    logic [7:0]       tdata_q;
    logic             tvalid_q;

    logic [WIDTH-1:0] cur;
    logic             vld;
    logic [LW-1:0]    len_eff;
    logic             arm_ok, is_imm, rise, fall, trig, store;
    logic             hs, stopping, byte_last, frame_last, dump_start, load_next;
    logic             ram_we, ram_re;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [WIDTH-1:0] ram_rdata;
    logic [SW-1:0]    pad;
    logic [15:0]      len16;

    // Select the latched capture channel
    always_comb begin
        cur = '0;
        vld = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (ch_q == CH_W'(k)) begin
                cur = i_tdata[k*WIDTH +: WIDTH];
                vld = i_tvalid[k];
            end
        end
    end

    // Effective frame length: 0 or oversize requests mean a full buffer
    always_comb begin
        if (frame_len == '0 || frame_len > LW'(DEPTH)) len_eff = LW'(DEPTH);
        else                                          len_eff = frame_len;
    end

    // Trigger, capture and handshake qualifiers
    always_comb begin
        arm_ok     = (state_q == ST_IDLE) && arm && !abort;
        is_imm     = (mode_q == TRIG_IMM) || (mode_q == TRIG_IMM_ALT);
        rise       = prev_vld_q && (prev_q < level_q) && (cur >= level_q);
        fall       = prev_vld_q && (prev_q >= level_q) && (cur < level_q);
        trig       = (state_q == ST_WAIT_TRIG) && vld && !abort &&
                     (is_imm || (mode_q == TRIG_RISE && rise) || (mode_q == TRIG_FALL && fall));
        store      = (state_q == ST_CAPTURE) && vld && !abort && (dcnt_q == decim_q);
        hs         = tvalid_q && o_tready;
        stopping   = abort || abort_pend_q;
        byte_last  = (byte_cnt_q == 3'(BYTES - 1));
        frame_last = !in_hdr_q && byte_last && (samp_cnt_q == len_q - 1'b1);
        dump_start = (state_q == ST_DUMP) && !tvalid_q && !abort;
        // Prefetch the next sample whenever one is moved into the serialiser so
        // the registered RAM read never stalls a back-to-back stream.
        load_next  = (state_q == ST_DUMP) && hs && !stopping &&
                     ((in_hdr_q && hdr_cnt_q == 2'd3) || (!in_hdr_q && byte_last && !frame_last));
        ram_we     = trig || store;
        ram_waddr  = trig ? '0 : wcnt_q[AW-1:0];
        ram_re     = dump_start || load_next;
        ram_raddr  = dump_start ? '0 : rd_ptr_q;
        pad        = SW'(ram_rdata);
        len16      = 16'(len_q);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (arm_ok) state_d = ST_WAIT_TRIG;
            ST_WAIT_TRIG: begin
                if (abort)     state_d = ST_IDLE;
                else if (trig) state_d = (len_q == LW'(1)) ? ST_DUMP : ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (abort)                                     state_d = ST_IDLE;
                else if (store && (wcnt_q + LW'(1) == len_q)) state_d = ST_DUMP;
            end
            ST_DUMP: begin
                if (!tvalid_q) begin
                    if (abort) state_d = ST_IDLE;
                end else if (hs && (stopping || frame_last)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Config latch, trigger history, decimation and dump serialiser
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch_q         <= '0;
            mode_q       <= TRIG_IMM;
            level_q      <= '0;
            len_q        <= '0;
            decim_q      <= '0;
            prev_q       <= '0;
            prev_vld_q   <= 1'b0;
            wcnt_q       <= '0;
            dcnt_q       <= '0;
            samp_cnt_q   <= '0;
            rd_ptr_q     <= '0;
            sh_q         <= '0;
            hdr_cnt_q    <= '0;
            in_hdr_q     <= 1'b0;
            byte_cnt_q   <= '0;
            abort_pend_q <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
        end else begin
            if (arm_ok) begin
                ch_q       <= ch_sel;
                mode_q     <= trig_mode_t'(trig_mode);
                level_q    <= trig_level;
                len_q      <= len_eff;
                decim_q    <= decim;
                prev_q     <= '0;
                prev_vld_q <= 1'b0;
                wcnt_q     <= '0;
                dcnt_q     <= '0;
            end
            if (state_q == ST_WAIT_TRIG && vld) begin
                prev_q     <= cur;
                prev_vld_q <= 1'b1;
            end
            if (trig) begin
                wcnt_q <= LW'(1);
                dcnt_q <= '0;
            end
            if (state_q == ST_CAPTURE && vld) begin
                if (dcnt_q == decim_q) begin
                    dcnt_q <= '0;
                    wcnt_q <= wcnt_q + 1'b1;
                end else begin
                    dcnt_q <= dcnt_q + 1'b1;
                end
            end
            if (dump_start) begin
                tvalid_q     <= 1'b1;
                tdata_q      <= SYNC_BYTE0;
                in_hdr_q     <= 1'b1;
                hdr_cnt_q    <= '0;
                samp_cnt_q   <= '0;
                byte_cnt_q   <= '0;
                rd_ptr_q     <= AW'(1);
                abort_pend_q <= 1'b0;
            end else if (state_q == ST_DUMP && tvalid_q) begin
                if (hs) begin
                    if (stopping || frame_last) begin
                        tvalid_q     <= 1'b0;
                        abort_pend_q <= 1'b0;
                    end else if (in_hdr_q) begin
                        if (hdr_cnt_q == 2'd3) begin
                            in_hdr_q   <= 1'b0;
                            byte_cnt_q <= '0;
                            samp_cnt_q <= '0;
                            tdata_q    <= pad[SW-1 -: 8];
                            sh_q       <= pad << 8;
                            rd_ptr_q   <= rd_ptr_q + 1'b1;
                        end else begin
                            hdr_cnt_q <= hdr_cnt_q + 2'd1;
                            tdata_q   <= header_byte(hdr_cnt_q + 2'd1, len16);
                        end
                    end else if (byte_last) begin
                        samp_cnt_q <= samp_cnt_q + 1'b1;
                        byte_cnt_q <= '0;
                        tdata_q    <= pad[SW-1 -: 8];
                        sh_q       <= pad << 8;
                        rd_ptr_q   <= rd_ptr_q + 1'b1;
                    end else begin
                        byte_cnt_q <= byte_cnt_q + 3'd1;
                        tdata_q    <= sh_q[SW-1 -: 8];
                        sh_q       <= sh_q << 8;
                    end
                end else if (abort) begin
                    abort_pend_q <= 1'b1;
                end
            end
        end
    end

    capture_ram #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (cur),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign o_tdata  = tdata_q;
    assign o_tvalid = tvalid_q;
    assign state    = state_q;
    assign done     = (state_q == ST_DUMP) && hs && frame_last && !stopping;

endmodule

// File: tb/tb_stream_capture_engine.sv
// Directed bench for stream_capture_engine (NUM_CH=4, WIDTH=16, DEPTH=16).
module tb_stream_capture_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] i_tdata = '0;
    logic [3:0]  i_tvalid = '0;
    logic [1:0]  ch_sel = '0;
    logic [1:0]  trig_mode = '0;
    logic [15:0] trig_level = '0;
    logic [4:0]  frame_len = '0;
    logic [7:0]  decim = '0;
    logic        arm = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  o_tdata;
    logic        o_tvalid;
    logic        o_tready = 1'b1;
    logic [1:0]  state;
    logic        done;

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    int done_base;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];
    logic       stall_q = 1'b0;
    logic [7:0] stall_data = '0;

    stream_capture_engine #(
        .NUM_CH(4),
        .WIDTH(16),
        .DEPTH(16),
        .DECIM_W(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_tdata    (i_tdata),
        .i_tvalid   (i_tvalid),
        .ch_sel     (ch_sel),
        .trig_mode  (trig_mode),
        .trig_level (trig_level),
        .frame_len  (frame_len),
        .decim      (decim),
        .arm        (arm),
        .abort      (abort),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .state      (state),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Collect accepted bytes, count done pulses, and check holds under backpressure
    always @(posedge clk) begin
        if (o_tvalid && o_tready) got.push_back(o_tdata);
        if (done) done_cnt++;
        if (rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid", 32'(o_tvalid), 32'd1);
                check("stall_data", 32'(o_tdata), 32'(stall_data));
            end
            stall_q    = o_tvalid && !o_tready;
            stall_data = o_tdata;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm_cfg(input int ch, input int mode, input int level, input int len, input int dec);
        ch_sel     = 2'(ch);
        trig_mode  = 2'(mode);
        trig_level = 16'(level);
        frame_len  = 5'(len);
        decim      = 8'(dec);
        arm        = 1'b1;
        step();
        arm        = 1'b0;
        check("armed", 32'(state), 32'd1);
    endtask

    task automatic send(input int ch, input int v);
        i_tdata[ch*16 +: 16] = 16'(v);
        i_tvalid = 4'(1 << ch);
        step();
        i_tvalid = '0;
    endtask

    task automatic wait_idle(input string tag, input int max_cyc);
        for (int k = 0; k < max_cyc && state != 2'd0; k++) step();
        check(tag, 32'(state), 32'd0);
    endtask

    task automatic wait_tvalid(input string tag, input int max_cyc);
        for (int k = 0; k < max_cyc && !o_tvalid; k++) step();
        check(tag, 32'(o_tvalid), 32'd1);
    endtask

    task automatic exp_hdr(input int len);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(len >> 8));
        exp_q.push_back(8'(len));
    endtask

    task automatic exp_smp(input int v);
        exp_q.push_back(8'(v >> 8));
        exp_q.push_back(8'(v));
    endtask

    task automatic check_bytes(input string tag);
        int n;
        check($sformatf("%s_count", tag), 32'(got.size()), 32'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    endtask

    initial begin
        // Reset values
        step();
        step();
        check("rst_state", 32'(state), 32'd0);
        check("rst_tvalid", 32'(o_tvalid), 32'd0);
        check("rst_tdata", 32'(o_tdata), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        step();

        // 1: immediate trigger, four samples on ch0
        got.delete();
        done_base = done_cnt;
        arm_cfg(0, 0, 0, 4, 0);
        send(0, 1); send(0, 2); send(0, 3); send(0, 4);
        wait_idle("t1_idle", 100);
        step();
        exp_hdr(4); exp_smp(1); exp_smp(2); exp_smp(3); exp_smp(4);
        check_bytes("t1");
        check("t1_done", 32'(done_cnt - done_base), 32'd1);
        check("t1_tvalid_low", 32'(o_tvalid), 32'd0);

        // 2: rising trigger on ch2, other channels ignored
        got.delete();
        arm_cfg(2, 1, 100, 4, 0);
        send(2, 100); send(2, 105);
        check("t2_first_at_level", 32'(state), 32'd1);
        send(3, 99); send(1, 150); send(0, 200);
        check("t2_other_ch", 32'(state), 32'd1);
        send(2, 90); send(2, 95);
        check("t2_below", 32'(state), 32'd1);
        send(2, 100);
        check("t2_trig", 32'(state), 32'd2);
        send(2, 105); send(2, 110); send(2, 115);
        wait_idle("t2_idle", 100);
        step();
        exp_hdr(4); exp_smp(100); exp_smp(105); exp_smp(110); exp_smp(115);
        check_bytes("t2");

        // 3: falling trigger with decimation
        got.delete();
        arm_cfg(1, 2, 50, 3, 2);
        for (int v = 60; v >= 0; v--) send(1, v);
        wait_idle("t3_idle", 100);
        step();
        exp_hdr(3); exp_smp(49); exp_smp(46); exp_smp(43);
        check_bytes("t3");

        // 4: full-depth frame (mode 3), random backpressure
        got.delete();
        done_base = done_cnt;
        arm_cfg(3, 3, 0, 0, 0);
        for (int k = 0; k < 16; k++) begin
            o_tready = 1'($urandom_range(0, 1));
            send(3, 16'h1000 + k * 16'h0101);
        end
        for (int k = 0; k < 600 && state != 2'd0; k++) begin
            o_tready = 1'($urandom_range(0, 1));
            step();
        end
        o_tready = 1'b1;
        check("t4_idle", 32'(state), 32'd0);
        step();
        exp_hdr(16);
        for (int k = 0; k < 16; k++) exp_smp(16'h1000 + k * 16'h0101);
        check_bytes("t4");
        check("t4_done", 32'(done_cnt - done_base), 32'd1);

        // 5a: abort in CAPTURE
        got.delete();
        arm_cfg(0, 0, 0, 8, 0);
        send(0, 1); send(0, 2);
        check("t5a_capture", 32'(state), 32'd2);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t5a_idle", 32'(state), 32'd0);
        repeat (10) step();
        check("t5a_no_bytes", 32'(got.size()), 32'd0);
        check("t5a_tvalid", 32'(o_tvalid), 32'd0);

        // 5b: abort in DUMP while stalled
        got.delete();
        done_base = done_cnt;
        o_tready = 1'b0;
        arm_cfg(0, 0, 0, 2, 0);
        send(0, 7); send(0, 8);
        wait_tvalid("t5b_tvalid", 20);
        check("t5b_first", 32'(o_tdata), 32'hA5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        repeat (3) step();
        check("t5b_hold_valid", 32'(o_tvalid), 32'd1);
        check("t5b_hold_data", 32'(o_tdata), 32'hA5);
        check("t5b_hold_state", 32'(state), 32'd3);
        o_tready = 1'b1;
        step();
        check("t5b_drop", 32'(o_tvalid), 32'd0);
        check("t5b_idle", 32'(state), 32'd0);
        check("t5b_bytes", 32'(got.size()), 32'd1);
        check("t5b_no_done", 32'(done_cnt - done_base), 32'd0);

        // 6a: reset during DUMP
        o_tready = 1'b0;
        arm_cfg(0, 0, 0, 4, 0);
        send(0, 1); send(0, 2); send(0, 3); send(0, 4);
        wait_tvalid("t6a_tvalid", 20);
        rst = 1'b1;
        #1;
        check("t6a_tvalid", 32'(o_tvalid), 32'd0);
        check("t6a_state", 32'(state), 32'd0);
        check("t6a_tdata", 32'(o_tdata), 32'd0);
        step();
        rst = 1'b0;
        o_tready = 1'b1;
        step();
        check("t6a_after", 32'(state), 32'd0);

        // 6b: arm during CAPTURE ignored
        got.delete();
        arm_cfg(0, 0, 0, 4, 0);
        send(0, 5);
        check("t6b_capture", 32'(state), 32'd2);
        ch_sel = 2'd1;
        frame_len = 5'd1;
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("t6b_arm_ignored", 32'(state), 32'd2);
        send(0, 6); send(0, 7); send(0, 8);
        wait_idle("t6b_idle", 100);
        step();
        exp_hdr(4); exp_smp(5); exp_smp(6); exp_smp(7); exp_smp(8);
        check_bytes("t6b");

        // 6c: arm and abort together in IDLE
        arm = 1'b1;
        abort = 1'b1;
        step();
        arm = 1'b0;
        abort = 1'b0;
        check("t6c_idle", 32'(state), 32'd0);
        step();
        check("t6c_still_idle", 32'(state), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
